// File: rtl/pq_pkg.sv
// Purpose : shared types and constants for the shift-register priority queue.
// Contents: default geometry, entry layout helpers, operation and FSM state
//           encodings, and bit positions inside the sticky error vector.
package pq_pkg;

    // Default geometry. An entry is {valid, key, val}; the key/value widths are
    // module parameters, so the entry is carried as separate fields rather than
    // a fixed packed struct.
    localparam int PQ_DEPTH_DEF = 16;
    localparam int PQ_KEY_W_DEF = 8;
    localparam int PQ_VAL_W_DEF = 8;

    // Width of one stored entry including its valid bit.
    function automatic int pq_entry_w(input int key_w, input int val_w);
        return 1 + key_w + val_w;
    endfunction

    // Operation selected from the strobes in a given cycle.
    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ENQ  = 2'd1,
        OP_DEQ  = 2'd2,
        OP_REPL = 2'd3
    } pq_op_e;

    // Controller states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REPL = 1'b1
    } pq_state_e;

    // Bit positions in err[2:0].
    localparam int ERR_OVF   = 0;
    localparam int ERR_UDF   = 1;
    localparam int ERR_MULTI = 2;

endpackage

// File: rtl/pq_sr_cell.sv
// Purpose : one storage cell of the shift-register priority queue.
// Ports   : clk/rst          clock, synchronous active-high reset
//           i_prev_*         entry held by the cell above (closer to the top)
//           i_next_*         entry held by the cell below
//           i_new_key/val    entry being inserted
//           i_shift_up       take the entry from below (dequeue)
//           i_ins_en         insert i_new_* at its ordered position
//           o_valid/key/val  this cell's stored entry
module pq_sr_cell
    import pq_pkg::*;
#(
    parameter int KEY_W     = PQ_KEY_W_DEF,
    parameter int VAL_W     = PQ_VAL_W_DEF,
    parameter bit MIN_FIRST = 1'b1,
    parameter bit IS_TOP    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_prev_valid,
    input  logic [KEY_W-1:0] i_prev_key,
    input  logic [VAL_W-1:0] i_prev_val,
    input  logic             i_next_valid,
    input  logic [KEY_W-1:0] i_next_key,
    input  logic [VAL_W-1:0] i_next_val,
    input  logic [KEY_W-1:0] i_new_key,
    input  logic [VAL_W-1:0] i_new_val,
    input  logic             i_shift_up,
    input  logic             i_ins_en,
    output logic             o_valid,
    output logic [KEY_W-1:0] o_key,
    output logic [VAL_W-1:0] o_val
);

    logic             r_valid;
    logic [KEY_W-1:0] r_key;
    logic [VAL_W-1:0] r_val;

    logic w_beats_prev;
    logic w_beats_self;
    logic w_take_new;

    // Strict comparison: an equal key is never "better", which places a new
    // entry behind existing equal keys.
    function automatic logic better(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
        return MIN_FIRST ? (a < b) : (a > b);
    endfunction

    always_comb begin
        w_beats_prev = i_prev_valid && better(i_new_key, i_prev_key);
        w_beats_self = !r_valid || better(i_new_key, r_key);
        // Only the first cell whose content loses to the new entry takes it;
        // cells past the tail have an invalid neighbour above and stay empty.
        w_take_new   = w_beats_self && (IS_TOP || (i_prev_valid && !w_beats_prev));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_key   <= '0;
            r_val   <= '0;
        end else if (i_shift_up) begin
            r_valid <= i_next_valid;
            r_key   <= i_next_key;
            r_val   <= i_next_val;
        end else if (i_ins_en) begin
            if (w_beats_prev) begin
                r_valid <= i_prev_valid;
                r_key   <= i_prev_key;
                r_val   <= i_prev_val;
            end else if (w_take_new) begin
                r_valid <= 1'b1;
                r_key   <= i_new_key;
                r_val   <= i_new_val;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_key   = r_key;
    assign o_val   = r_val;

endmodule

// File: rtl/pq_sr_erd.sv
// Purpose : shift-register priority queue with enqueue, dequeue and a
//           two-cycle replace (pop top, then insert the latched entry).
// Ports   : clk, rst                  clock, synchronous active-high reset
//           kvi_key/kvi_val           entry for enq/replace
//           enq, deq, replace         single-cycle command strobes
//           full, empty, busy         status (busy = replace in progress)
//           kvo_key/kvo_val           top entry, 0 when empty
//           count                     occupancy
//           err                       sticky {multi_cmd, underflow, overflow}
// Handshake: strobes are only sampled while busy=0; a strobe during busy is
//           dropped silently. Results appear the cycle after the strobe.
module pq_sr_erd
    import pq_pkg::*;
#(
    parameter int DEPTH     = PQ_DEPTH_DEF,
    parameter int KEY_W     = PQ_KEY_W_DEF,
    parameter int VAL_W     = PQ_VAL_W_DEF,
    parameter bit MIN_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [KEY_W-1:0]           kvi_key,
    input  logic [VAL_W-1:0]           kvi_val,
    input  logic                       enq,
    input  logic                       deq,
    input  logic                       replace,
    output logic                       full,
    output logic                       empty,
    output logic                       busy,
    output logic [KEY_W-1:0]           kvo_key,
    output logic [VAL_W-1:0]           kvo_val,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [2:0]                 err
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    pq_state_e        r_state;
    pq_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [KEY_W-1:0] r_lat_key;
    logic [VAL_W-1:0] r_lat_val;
    logic [2:0]       r_err;

    pq_op_e           w_op;
    logic [1:0]       w_n_strobes;
    logic             w_multi;
    logic             w_full;
    logic             w_empty;
    logic             w_shift_up;
    logic             w_ins_en;
    logic [KEY_W-1:0] w_new_key;
    logic [VAL_W-1:0] w_new_val;

    logic             w_cell_valid [DEPTH];
    logic [KEY_W-1:0] w_cell_key   [DEPTH];
    logic [VAL_W-1:0] w_cell_val   [DEPTH];

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // Command decode: replace > deq > enq. Replace on an empty queue has
    // nothing to pop, so it is carried out as a plain enqueue.
    always_comb begin
        w_n_strobes = {1'b0, enq} + {1'b0, deq} + {1'b0, replace};
        w_op        = OP_NONE;
        if (r_state == ST_IDLE) begin
            if (replace)  w_op = w_empty ? OP_ENQ : OP_REPL;
            else if (deq) w_op = OP_DEQ;
            else if (enq) w_op = OP_ENQ;
        end
        w_multi    = (r_state == ST_IDLE) && (w_n_strobes > 2'd1);
        w_shift_up = (w_op == OP_DEQ && !w_empty) || (w_op == OP_REPL);
        // The REPL insert follows a pop, so there is always a free cell.
        w_ins_en   = (w_op == OP_ENQ && !w_full) || (r_state == ST_REPL);
        w_new_key  = (r_state == ST_REPL) ? r_lat_key : kvi_key;
        w_new_val  = (r_state == ST_REPL) ? r_lat_val : kvi_val;
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_op == OP_REPL) w_state_nxt = ST_REPL;
            ST_REPL: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (r_state == ST_REPL);
    end

    // Replace latch, occupancy and sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lat_key <= '0;
            r_lat_val <= '0;
            r_count   <= '0;
            r_err     <= '0;
        end else begin
            if (w_op == OP_REPL) begin
                r_lat_key <= kvi_key;
                r_lat_val <= kvi_val;
            end
            if (w_shift_up)    r_count <= r_count - CNT_W'(1);
            else if (w_ins_en) r_count <= r_count + CNT_W'(1);
            if (w_multi)                     r_err[ERR_MULTI] <= 1'b1;
            if (w_op == OP_ENQ && w_full)    r_err[ERR_OVF]   <= 1'b1;
            if (w_op == OP_DEQ && w_empty)   r_err[ERR_UDF]   <= 1'b1;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        logic             w_pv;
        logic [KEY_W-1:0] w_pk;
        logic [VAL_W-1:0] w_pval;
        logic             w_nv;
        logic [KEY_W-1:0] w_nk;
        logic [VAL_W-1:0] w_nval;

        if (g == 0) begin : g_top
            assign w_pv   = 1'b0;
            assign w_pk   = '0;
            assign w_pval = '0;
        end else begin : g_mid
            assign w_pv   = w_cell_valid[g-1];
            assign w_pk   = w_cell_key[g-1];
            assign w_pval = w_cell_val[g-1];
        end

        // The bottom cell refills with an empty entry on a shift up.
        if (g == DEPTH - 1) begin : g_bot
            assign w_nv   = 1'b0;
            assign w_nk   = '0;
            assign w_nval = '0;
        end else begin : g_up
            assign w_nv   = w_cell_valid[g+1];
            assign w_nk   = w_cell_key[g+1];
            assign w_nval = w_cell_val[g+1];
        end

        pq_sr_cell #(
            .KEY_W     (KEY_W),
            .VAL_W     (VAL_W),
            .MIN_FIRST (MIN_FIRST),
            .IS_TOP    (g == 0)
        ) u_cell (
            .clk          (clk),
            .rst          (rst),
            .i_prev_valid (w_pv),
            .i_prev_key   (w_pk),
            .i_prev_val   (w_pval),
            .i_next_valid (w_nv),
            .i_next_key   (w_nk),
            .i_next_val   (w_nval),
            .i_new_key    (w_new_key),
            .i_new_val    (w_new_val),
            .i_shift_up   (w_shift_up),
            .i_ins_en     (w_ins_en),
            .o_valid      (w_cell_valid[g]),
            .o_key        (w_cell_key[g]),
            .o_val        (w_cell_val[g])
        );
    end

    assign full    = w_full;
    assign empty   = w_empty;
    assign count   = r_count;
    assign err     = r_err;
    assign kvo_key = w_cell_valid[0] ? w_cell_key[0] : '0;
    assign kvo_val = w_cell_valid[0] ? w_cell_val[0] : '0;

endmodule

// File: tb/tb_pq_sr_erd.sv
module tb_pq_sr_erd;

  localparam int DEPTH = 4;
  localparam int EW    = 41;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       enq, deq, replace;
  logic [7:0] kvi_key, kvi_val;

  logic       full_a, empty_a, busy_a;
  logic [7:0] key_a, val_a;
  logic [2:0] count_a, err_a;
  logic       full_b, empty_b, busy_b;
  logic [7:0] key_b, val_b;
  logic [2:0] count_b, err_b;

  // smallest-first instance
  pq_sr_erd #(.DEPTH(DEPTH), .KEY_W(8), .VAL_W(8), .MIN_FIRST(1'b1)) dut_min (
    .clk(clk), .rst(rst), .kvi_key(kvi_key), .kvi_val(kvi_val),
    .enq(enq), .deq(deq), .replace(replace),
    .full(full_a), .empty(empty_a), .busy(busy_a),
    .kvo_key(key_a), .kvo_val(val_a), .count(count_a), .err(err_a)
  );

  // largest-first instance, same stimulus
  pq_sr_erd #(.DEPTH(DEPTH), .KEY_W(8), .VAL_W(8), .MIN_FIRST(1'b0)) dut_max (
    .clk(clk), .rst(rst), .kvi_key(kvi_key), .kvi_val(kvi_val),
    .enq(enq), .deq(deq), .replace(replace),
    .full(full_b), .empty(empty_b), .busy(busy_b),
    .kvo_key(key_b), .kvo_val(val_b), .count(count_b), .err(err_b)
  );

  // ---------------- reference model ----------------
  typedef struct packed { logic [7:0] k; logic [7:0] v; } ent_t;
  ent_t       m_min[$];
  ent_t       m_max[$];
  logic [2:0] m_err;
  logic       m_busy;

  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ties go behind existing equal keys
  task automatic mdl_ins(input logic [7:0] k, input logic [7:0] v);
    ent_t e;
    int   pos;
    e.k = k;
    e.v = v;
    pos = m_min.size();
    for (int i = 0; i < m_min.size(); i++)
      if (k < m_min[i].k) begin pos = i; break; end
    m_min.insert(pos, e);
    pos = m_max.size();
    for (int i = 0; i < m_max.size(); i++)
      if (k > m_max[i].k) begin pos = i; break; end
    m_max.insert(pos, e);
  endtask

  task automatic mdl_pop();
    m_min.delete(0);
    m_max.delete(0);
  endtask

  task automatic mdl_clear();
    m_min.delete();
    m_max.delete();
    m_err  = 3'b000;
    m_busy = 1'b0;
  endtask

  // {min_k, min_v, max_k, max_v, count, full, empty, busy, err}
  task automatic push_exp();
    logic [EW-1:0] s;
    int n;
    n = m_min.size();
    s = '0;
    if (n > 0) begin
      s[40:33] = m_min[0].k;
      s[32:25] = m_min[0].v;
      s[24:17] = m_max[0].k;
      s[16:9]  = m_max[0].v;
    end
    s[8:6] = 3'(n);
    s[5]   = (n == DEPTH);
    s[4]   = (n == 0);
    s[3]   = m_busy;
    s[2:0] = m_err;
    exp_q.push_back(s);
  endtask

  task automatic compare_one(input string tag);
    logic [EW-1:0] e;
    check_val({tag, ".sb_avail"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val({tag, ".key_min"}, 32'(key_a),   32'(e[40:33]));
      check_val({tag, ".val_min"}, 32'(val_a),   32'(e[32:25]));
      check_val({tag, ".key_max"}, 32'(key_b),   32'(e[24:17]));
      check_val({tag, ".val_max"}, 32'(val_b),   32'(e[16:9]));
      check_val({tag, ".count"},   32'(count_a), 32'(e[8:6]));
      check_val({tag, ".count_b"}, 32'(count_b), 32'(e[8:6]));
      check_val({tag, ".full"},    32'(full_a),  32'(e[5]));
      check_val({tag, ".empty"},   32'(empty_a), 32'(e[4]));
      check_val({tag, ".busy"},    32'(busy_a),  32'(e[3]));
      check_val({tag, ".busy_b"},  32'(busy_b),  32'(e[3]));
      check_val({tag, ".err"},     32'(err_a),   32'(e[2:0]));
      check_val({tag, ".err_b"},   32'(err_b),   32'(e[2:0]));
      check_val({tag, ".empty_b"}, 32'(empty_b), 32'(e[4]));
      check_val({tag, ".full_b"},  32'(full_b),  32'(e[5]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; enq = 1'b0; deq = 1'b0; replace = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mdl_clear();
    push_exp();
    compare_one(tag);
  endtask

  // poke: strobe deq during the busy cycle (must be ignored)
  task automatic drive(input logic e, input logic d, input logic r,
                       input logic [7:0] k, input logic [7:0] v,
                       input logic poke, input string tag);
    int   n;
    logic pend;
    @(negedge clk);
    enq = e; deq = d; replace = r; kvi_key = k; kvi_val = v;
    n = int'(e) + int'(d) + int'(r);
    if (n > 1) m_err[2] = 1'b1;
    pend = 1'b0;
    if (r) begin
      if (m_min.size() == 0) mdl_ins(k, v);
      else begin mdl_pop(); pend = 1'b1; end
    end else if (d) begin
      if (m_min.size() == 0) m_err[1] = 1'b1;
      else mdl_pop();
    end else if (e) begin
      if (m_min.size() == DEPTH) m_err[0] = 1'b1;
      else mdl_ins(k, v);
    end
    m_busy = pend;
    push_exp();
    @(negedge clk);
    enq = 1'b0; deq = 1'b0; replace = 1'b0;
    if (pend) begin
      kvi_key = ~k;
      kvi_val = ~v;
      deq = poke;
    end
    compare_one(tag);
    if (pend) begin
      mdl_ins(k, v);
      m_busy = 1'b0;
      push_exp();
      @(negedge clk);
      deq = 1'b0;
      compare_one({tag, "_fin"});
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; enq = 1'b0; deq = 1'b0; replace = 1'b0;
    kvi_key = 8'd0; kvi_val = 8'd0;
    mdl_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_exp();
    compare_one("por");

    // reset while the replace insert is pending
    drive(1'b1, 1'b0, 1'b0, 8'd5, 8'd1, 1'b0, "t1_enq");
    @(negedge clk);
    replace = 1'b1; kvi_key = 8'd7; kvi_val = 8'd2;
    mdl_pop(); m_busy = 1'b1; push_exp();
    @(negedge clk);
    replace = 1'b0;
    compare_one("t1_mid");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdl_clear();
    push_exp();
    compare_one("t1_rst");

    // ordering and FIFO among equal keys
    drive(1'b1, 1'b0, 1'b0, 8'd5, 8'd1, 1'b0, "t2_e5");
    drive(1'b1, 1'b0, 1'b0, 8'd3, 8'd2, 1'b0, "t2_e3");
    drive(1'b1, 1'b0, 1'b0, 8'd9, 8'd3, 1'b0, "t2_e9");
    drive(1'b1, 1'b0, 1'b0, 8'd3, 8'd7, 1'b0, "t2_e3b");
    for (int i = 0; i < 4; i++)
      drive(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, "t2_deq");

    // fill and overflow
    do_reset("t3_rst");
    drive(1'b1, 1'b0, 1'b0, 8'd1, 8'd11, 1'b0, "t3_e1");
    drive(1'b1, 1'b0, 1'b0, 8'd2, 8'd12, 1'b0, "t3_e2");
    drive(1'b1, 1'b0, 1'b0, 8'd3, 8'd13, 1'b0, "t3_e3");
    drive(1'b1, 1'b0, 1'b0, 8'd4, 8'd14, 1'b0, "t3_e4");
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd10, 1'b0, "t3_ovf");
    drive(1'b0, 1'b0, 1'b1, 8'd2, 8'd20, 1'b1, "t3_repl_full");

    // replace into the middle
    do_reset("t4_rst");
    drive(1'b1, 1'b0, 1'b0, 8'd2, 8'd1, 1'b0, "t4_e2");
    drive(1'b1, 1'b0, 1'b0, 8'd6, 8'd2, 1'b0, "t4_e6");
    drive(1'b1, 1'b0, 1'b0, 8'd8, 8'd3, 1'b0, "t4_e8");
    drive(1'b0, 1'b0, 1'b1, 8'd7, 8'd4, 1'b1, "t4_repl");
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, "t4_drain");

    // empty-queue corner cases
    do_reset("t5_rst");
    drive(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, "t5_udf");
    drive(1'b0, 1'b0, 1'b1, 8'd4, 8'd9, 1'b0, "t5_repl_empty");

    // conflicting strobes
    do_reset("t6_rst");
    drive(1'b1, 1'b0, 1'b0, 8'd5, 8'd5, 1'b0, "t6_e5");
    drive(1'b1, 1'b1, 1'b0, 8'd1, 8'd1, 1'b0, "t6_multi");

    // random traffic with small keys to force ties
    do_reset("rnd_rst");
    for (int i = 0; i < 60; i++) begin
      logic e, d, r;
      int   sel;
      sel = $urandom_range(0, 9);
      e = (sel <= 3) || (sel == 8);
      d = (sel == 4) || (sel == 5) || (sel == 8) || (sel == 9);
      r = (sel == 6) || (sel == 7) || (sel == 9);
      drive(e, d, r, 8'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), "rnd");
    end

    check_val("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
